// File: rtl/vga_scanout.sv
// vga_scanout -- 640x480@60 VGA scan-out engine for a 160x120, 12-bit framebuffer.
//
// The 50 MHz clock is divided by a toggling pixel enable, so one screen pixel
// lasts two clocks. Every framebuffer pixel covers a 4x4 block on screen.
// The framebuffer RAM is read synchronously; all pins come straight from flops.
//
// Ports
//   CLK1_50      in   system clock, the only clock
//   RST          in   synchronous, active-high reset
//   FB_ADDR      out  framebuffer read address, (vc>>2)*160 + (hc>>2), 0 when blanked
//   FB_DATA      in   {R,G,B} from the RAM, valid one clock after FB_ADDR
//   VGA_R/G/B    out  4-bit colour, forced to 0 outside the active area
//   VGA_HS       out  horizontal sync, active low
//   VGA_VS       out  vertical sync, active low
//   FRAME_START  out  one-clock pulse when the scan wraps from (799,524) to (0,0)
//   VBLANK       out  high while the displayed line is below the active area
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        CLK1_50,
    input  logic        RST,
    output logic [14:0] FB_ADDR,
    input  logic [11:0] FB_DATA,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        FRAME_START,
    output logic        VBLANK
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Scan position and pixel enable
    logic        pix_en_q, pix_en_d;
    logic [9:0]  hc_q, hc_d;
    logic [9:0]  vc_q, vc_d;
    logic        frame_start_q, frame_start_d;

    // Stage A: address plus timing flags for the current position
    logic [14:0] fb_addr_q, fb_addr_d;
    logic        active_a_q, active_a_d;
    logic        hs_a_q, hs_a_d;
    logic        vs_a_q, vs_a_d;
    logic        vblank_a_q, vblank_a_d;

    // Stage B: pin registers
    logic [11:0] rgb_q, rgb_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        vblank_q, vblank_d;

    // Scratch for the address computation
    logic        active_next;
    logic [14:0] row, col;

    // NOTE: every signal assigned here gets a default first, so no path through
    // the block can leave a value unassigned and infer a latch.
    always_comb begin
        pix_en_d      = ~pix_en_q;
        hc_d          = hc_q;
        vc_d          = vc_q;
        frame_start_d = 1'b0;

        if (pix_en_q) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                if (vc_q == V_LAST) begin
                    vc_d          = '0;
                    frame_start_d = 1'b1;
                end else begin
                    vc_d = vc_q + 10'd1;
                end
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end

        // The address is formed from the next position so that it changes on
        // the same edge as the counters; the RAM then answers one clock later
        // and stage B picks the word up exactly when the delayed flags arrive.
        active_next = (hc_d < H_ACT) && (vc_d < V_ACT);
        row         = 15'(vc_d >> 2);
        col         = 15'(hc_d >> 2);
        // row*160 as two shifts: row*128 + row*32
        fb_addr_d   = active_next ? ((row << 7) + (row << 5) + col) : 15'd0;

        active_a_d  = (hc_q < H_ACT) && (vc_q < V_ACT);
        hs_a_d      = !((hc_q >= HS_FIRST) && (hc_q <= HS_LAST));
        vs_a_d      = !((vc_q >= VS_FIRST) && (vc_q <= VS_LAST));
        vblank_a_d  = (vc_q >= V_ACT);

        // RAM data is only taken while the delayed position is visible.
        rgb_d       = active_a_q ? FB_DATA : 12'h000;
        hs_d        = hs_a_q;
        vs_d        = vs_a_q;
        vblank_d    = vblank_a_q;
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge CLK1_50) begin
        if (RST) begin
            pix_en_q      <= 1'b0;
            hc_q          <= '0;
            vc_q          <= '0;
            frame_start_q <= 1'b0;
            fb_addr_q     <= '0;
            active_a_q    <= 1'b0;
            hs_a_q        <= 1'b1;
            vs_a_q        <= 1'b1;
            vblank_a_q    <= 1'b0;
            rgb_q         <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            vblank_q      <= 1'b0;
        end else begin
            pix_en_q      <= pix_en_d;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            frame_start_q <= frame_start_d;
            fb_addr_q     <= fb_addr_d;
            active_a_q    <= active_a_d;
            hs_a_q        <= hs_a_d;
            vs_a_q        <= vs_a_d;
            vblank_a_q    <= vblank_a_d;
            rgb_q         <= rgb_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            vblank_q      <= vblank_d;
        end
    end

    assign FB_ADDR     = fb_addr_q;
    assign VGA_R       = rgb_q[11:8];
    assign VGA_G       = rgb_q[7:4];
    assign VGA_B       = rgb_q[3:0];
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign FRAME_START = frame_start_q;
    assign VBLANK      = vblank_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout -- self-checking bench for vga_scanout.
// Horizontal timing uses the real 640/16/96/48 values; the vertical timing is
// shortened (8 active lines, 15 in total) so several frames fit in a short run.
module tb_vga_scanout;

    localparam int HA = 640, HFP = 16, HSW = 96, HBP = 48;
    localparam int VA = 8, VFP = 2, VSW = 2, VBP = 3;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME_CLK = 2 * HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fb_mode = 1'b0;
    logic [14:0] fb_addr;
    logic [11:0] fb_data;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, frame_start, vblank;

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
    ) dut (
        .CLK1_50     (clk),
        .RST         (rst),
        .FB_ADDR     (fb_addr),
        .FB_DATA     (fb_data),
        .VGA_R       (vga_r),
        .VGA_G       (vga_g),
        .VGA_B       (vga_b),
        .VGA_HS      (vga_hs),
        .VGA_VS      (vga_vs),
        .FRAME_START (frame_start),
        .VBLANK      (vblank)
    );

    always #10 clk = ~clk;

    // Synchronous framebuffer RAM model: data appears one clock after the address.
    always @(posedge clk) fb_data <= fb_mode ? 12'hFFF : fb_addr[11:0];

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        vb;
        logic [11:0] rgb;
    } pins_t;

    typedef struct {
        int          n;
        logic [14:0] addr;
        logic        hs;
        logic        vs;
        logic        vb;
    } probe_t;

    localparam pins_t RESET_PINS = '{hs: 1'b1, vs: 1'b1, vb: 1'b0, rgb: 12'h000};

    int    passed = 0;
    int    total  = 0;

    // Reference scan model
    int    n = 0;
    int    m_pix = 0, m_hc = 0, m_vc = 0;
    logic  m_fs = 1'b0;
    int    exp_addr = 0;
    pins_t exp_pins = RESET_PINS;
    pins_t sb_q[$];

    // Observed pin events (cycle numbers since release)
    int    hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$], vb_rise[$], vb_fall[$], fs_at[$];
    logic  prev_hs = 1'b1, prev_vs = 1'b1, prev_vb = 1'b0;

    probe_t probes[11];
    int     pi = 0;
    bit     probes_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic bit act_at(int h, int v);
        return (h < HA) && (v < VA);
    endfunction

    function automatic int addr_of(int h, int v);
        return act_at(h, v) ? (v / 4) * 160 + (h / 4) : 0;
    endfunction

    function automatic pins_t pins_of(int h, int v);
        pins_t p;
        p.hs  = !((h >= HA + HFP) && (h < HA + HFP + HSW));
        p.vs  = !((v >= VA + VFP) && (v < VA + VFP + VSW));
        p.vb  = (v >= VA);
        p.rgb = !act_at(h, v) ? 12'h000 : (fb_mode ? 12'hFFF : 12'(addr_of(h, v)));
        return p;
    endfunction

    // One clock: advance the model, pop the expected pins, compare, log events.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_pix = 0; m_hc = 0; m_vc = 0; m_fs = 1'b0; n = 0;
            exp_addr = 0;
            exp_pins = RESET_PINS;
            sb_q.delete();
            sb_q.push_back(RESET_PINS);   // stage A holds reset values
            sb_q.push_back(pins_of(0, 0)); // then (0,0) reaches the pins
        end else begin
            m_fs = 1'b0;
            if (m_pix != 0) begin
                if (m_hc == HT - 1) begin
                    m_hc = 0;
                    if (m_vc == VT - 1) begin m_vc = 0; m_fs = 1'b1; end
                    else m_vc++;
                end else begin
                    m_hc++;
                end
            end
            m_pix = (m_pix == 0) ? 1 : 0;
            n++;
            sb_q.push_back(pins_of(m_hc, m_vc));
            exp_pins = sb_q.pop_front();
            exp_addr = addr_of(m_hc, m_vc);
        end
        #1;
        check($sformatf("scan n=%0d", n),
              {fb_addr, frame_start, vga_hs, vga_vs, vblank, vga_r, vga_g, vga_b},
              {15'(exp_addr), m_fs, exp_pins.hs, exp_pins.vs, exp_pins.vb, exp_pins.rgb});
        if (!rst) begin
            if (prev_hs && !vga_hs) hs_fall.push_back(n);
            if (!prev_hs && vga_hs) hs_rise.push_back(n);
            if (prev_vs && !vga_vs) vs_fall.push_back(n);
            if (!prev_vs && vga_vs) vs_rise.push_back(n);
            if (!prev_vb && vblank) vb_rise.push_back(n);
            if (prev_vb && !vblank) vb_fall.push_back(n);
            if (frame_start) fs_at.push_back(n);
            if (probes_on && pi < 11 && probes[pi].n == n) begin
                check($sformatf("probe n=%0d", n), {fb_addr, vga_hs, vga_vs, vblank},
                      {probes[pi].addr, probes[pi].hs, probes[pi].vs, probes[pi].vb});
                pi++;
            end
        end
        prev_hs = vga_hs; prev_vs = vga_vs; prev_vb = vblank;
    endtask

    function automatic int at(int q[$], int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    initial begin
        // Cycle n after release: hc=k on line 0 is reached at n=2k; pins lag by 2.
        probes[0]  = '{2,     15'd0,   1'b1, 1'b1, 1'b0};
        probes[1]  = '{8,     15'd1,   1'b1, 1'b1, 1'b0};
        probes[2]  = '{1313,  15'd0,   1'b1, 1'b1, 1'b0};
        probes[3]  = '{1314,  15'd0,   1'b0, 1'b1, 1'b0};
        probes[4]  = '{6408,  15'd161, 1'b1, 1'b1, 1'b0};  // screen (4,4)
        probes[5]  = '{12478, 15'd319, 1'b1, 1'b1, 1'b0};  // screen (639,7)
        probes[6]  = '{12802, 15'd0,   1'b1, 1'b1, 1'b1};
        probes[7]  = '{16001, 15'd0,   1'b1, 1'b1, 1'b1};
        probes[8]  = '{16002, 15'd0,   1'b1, 1'b0, 1'b1};
        probes[9]  = '{19201, 15'd0,   1'b1, 1'b0, 1'b1};
        probes[10] = '{19202, 15'd0,   1'b1, 1'b1, 1'b1};

        // Reset held for three clocks
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Two full frames with the address-pattern framebuffer
        rst = 1'b0;
        probes_on = 1'b1;
        for (int i = 0; i < 2 * FRAME_CLK + 10; i++) step();
        probes_on = 1'b0;
        check("probes_seen", pi, 11);

        check("hs_first_fall", at(hs_fall, 0), 2 * (HA + HFP) + 2);
        check("hs_low_clk",    at(hs_rise, 0) - at(hs_fall, 0), 2 * HSW);
        check("hs_period",     at(hs_fall, 1) - at(hs_fall, 0), 2 * HT);
        check("vs_first_fall", at(vs_fall, 0), 2 * HT * (VA + VFP) + 2);
        check("vs_low_clk",    at(vs_rise, 0) - at(vs_fall, 0), 2 * HT * VSW);
        check("vs_period",     at(vs_fall, 1) - at(vs_fall, 0), FRAME_CLK);
        check("vblank_clk",    at(vb_fall, 0) - at(vb_rise, 0), 2 * HT * (VT - VA));
        check("fs_count",      fs_at.size(), 2);
        check("fs_first",      at(fs_at, 0), FRAME_CLK);
        check("fs_period",     at(fs_at, 1) - at(fs_at, 0), FRAME_CLK);

        // Walk to (hc,vc) = (300,5), bounded
        for (int i = 0; i < 20000 && !(m_vc == 5 && m_hc == 300); i++) step();
        check("addr_300_5", fb_addr, 15'd235);

        // One-clock reset mid-frame; the framebuffer now reads all-white
        rst = 1'b1;
        fb_mode = 1'b1;
        step();
        check("midrst_pins", {fb_addr, vga_hs, vga_vs, frame_start, vblank, vga_r, vga_g, vga_b},
              {15'd0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000});
        rst = 1'b0;
        fs_at.delete();
        for (int i = 0; i < FRAME_CLK + 10; i++) step();
        check("midrst_fs_count", fs_at.size(), 1);
        check("midrst_fs_at",    at(fs_at, 0), FRAME_CLK);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
